wbuf_read_sched: RTL

Read scheduler for the 6-bank dual-port weight buffer. It accepts up to four independent block-stream commands, one per array lane. Each cycle it turns them into WBUF bank, address, enable and port selects. It arbitrates when more than two lanes target the same bank, and returns per-lane valid and last tags aligned with the WBUF read data.

---
 rtl/wbuf_read_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/wbuf_read_sched.sv
// rtl/wbuf_read_sched.sv - read scheduler for the 6-bank dual-port weight buffer
//
// Purpose: turns up to N_LANE block-stream read commands into per-lane WBUF
// bank/address/enable/port selects. When several lanes hit the same bank, it
// arbitrates round-robin with at most two grants per bank (port A, then port B).
// It returns per-lane read-valid/last tags aligned with the 1-cycle WBUF data.
//
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_cmd_valid       per-lane command valid
//   o_cmd_ready       per-lane idle / command accept
//   i_cmd_bank/addr   per-lane start position (flattened, lane j at j*W)
//   i_cmd_len         per-lane number of blocks (0 = no reads)
//   i_stall           suppresses all new grants
//   o_bank_sel/addr_sel/en_sel/port_sel  registered WBUF selects (port 1 = B)
//   o_rd_valid/rd_last   en_sel and last tag delayed one more cycle
//   o_cmd_err         one-cycle pulse after accepting an out-of-range command
module wbuf_read_sched #(
  parameter int N_LANE = 4,
  parameter int N_BANK = 6,
  parameter int DEPTH  = 11,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BANK_W = $clog2(N_BANK),
  parameter int LEN_W  = $clog2(N_BANK*DEPTH+1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_LANE-1:0]        i_cmd_valid,
  output logic [N_LANE-1:0]        o_cmd_ready,
  input  logic [N_LANE*BANK_W-1:0] i_cmd_bank,
  input  logic [N_LANE*ADDR_W-1:0] i_cmd_addr,
  input  logic [N_LANE*LEN_W-1:0]  i_cmd_len,
  input  logic                     i_stall,
  output logic [N_LANE*BANK_W-1:0] o_bank_sel,
  output logic [N_LANE*ADDR_W-1:0] o_addr_sel,
  output logic [N_LANE-1:0]        o_en_sel,
  output logic [N_LANE-1:0]        o_port_sel,
  output logic [N_LANE-1:0]        o_rd_valid,
  output logic [N_LANE-1:0]        o_rd_last,
  output logic [N_LANE-1:0]        o_cmd_err
);

  localparam int PTR_W = $clog2(N_LANE);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANK - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state     [N_LANE];
  state_t            w_state_nxt [N_LANE];
  logic [BANK_W-1:0] r_cur_bank  [N_LANE];
  logic [ADDR_W-1:0] r_cur_addr  [N_LANE];
  logic [LEN_W-1:0]  r_rem       [N_LANE];
  logic [PTR_W-1:0]  r_rr_ptr;

  logic [BANK_W-1:0] w_ld_bank [N_LANE];
  logic [ADDR_W-1:0] w_ld_addr [N_LANE];
  logic [LEN_W-1:0]  w_ld_len  [N_LANE];
  logic [N_LANE-1:0] w_bad;
  logic [N_LANE-1:0] w_accept;
  logic [N_LANE-1:0] w_last;
  logic [N_LANE-1:0] w_grant;
  logic [N_LANE-1:0] w_port;
  logic [1:0]        w_bank_cnt [N_BANK];
  logic [PTR_W-1:0]  w_lane;

  logic [N_LANE*BANK_W-1:0] r_bank_sel;
  logic [N_LANE*ADDR_W-1:0] r_addr_sel;
  logic [N_LANE-1:0]        r_en_sel;
  logic [N_LANE-1:0]        r_port_sel;
  logic [N_LANE-1:0]        r_last_tag;
  logic [N_LANE-1:0]        r_rd_valid;
  logic [N_LANE-1:0]        r_rd_last;
  logic [N_LANE-1:0]        r_cmd_err;

  // Command field unpack; out-of-range fields load as 0 independently.
  always_comb begin
    for (int j = 0; j < N_LANE; j++) begin
      w_ld_bank[j] = i_cmd_bank[j*BANK_W +: BANK_W];
      w_ld_addr[j] = i_cmd_addr[j*ADDR_W +: ADDR_W];
      w_ld_len[j]  = i_cmd_len[j*LEN_W +: LEN_W];
      w_bad[j]     = (w_ld_bank[j] > LAST_BANK) || (w_ld_addr[j] > LAST_ADDR);
      if (w_ld_bank[j] > LAST_BANK) w_ld_bank[j] = '0;
      if (w_ld_addr[j] > LAST_ADDR) w_ld_addr[j] = '0;
    end
  end

  // Round-robin arbitration: walk lanes from r_rr_ptr and hand out at most two
  // grants per bank; the running per-bank count doubles as the port select.
  always_comb begin
    w_grant = '0;
    w_port  = '0;
    w_lane  = '0;
    for (int b = 0; b < N_BANK; b++) w_bank_cnt[b] = 2'd0;
    for (int k = 0; k < N_LANE; k++) begin
      w_lane = r_rr_ptr + PTR_W'(k);
      if (!i_stall && (r_state[w_lane] == S_RUN) &&
          (w_bank_cnt[r_cur_bank[w_lane]] != 2'd2)) begin
        w_grant[w_lane] = 1'b1;
        w_port[w_lane]  = w_bank_cnt[r_cur_bank[w_lane]][0];
        w_bank_cnt[r_cur_bank[w_lane]] = w_bank_cnt[r_cur_bank[w_lane]] + 2'd1;
      end
    end
  end

  // Per-lane FSM next state.
  always_comb begin
    for (int j = 0; j < N_LANE; j++) begin
      w_state_nxt[j] = r_state[j];
      w_accept[j]    = 1'b0;
      w_last[j]      = 1'b0;
      case (r_state[j])
        S_IDLE: begin
          if (i_cmd_valid[j]) begin
            w_accept[j] = 1'b1;
            // A zero-length command is consumed without ever running.
            if (w_ld_len[j] != '0) w_state_nxt[j] = S_RUN;
          end
        end
        S_RUN: begin
          if (w_grant[j] && (r_rem[j] == LEN_W'(1))) begin
            w_last[j]      = 1'b1;
            w_state_nxt[j] = S_IDLE;
          end
        end
        default: w_state_nxt[j] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int j = 0; j < N_LANE; j++) begin
        r_state[j]    <= S_IDLE;
        r_cur_bank[j] <= '0;
        r_cur_addr[j] <= '0;
        r_rem[j]      <= '0;
      end
      r_rr_ptr   <= '0;
      r_bank_sel <= '0;
      r_addr_sel <= '0;
      r_en_sel   <= '0;
      r_port_sel <= '0;
      r_last_tag <= '0;
      r_rd_valid <= '0;
      r_rd_last  <= '0;
      r_cmd_err  <= '0;
    end else begin
      for (int j = 0; j < N_LANE; j++) begin
        r_state[j] <= w_state_nxt[j];
        if (w_accept[j]) begin
          r_cur_bank[j] <= w_ld_bank[j];
          r_cur_addr[j] <= w_ld_addr[j];
          r_rem[j]      <= w_ld_len[j];
        end else if (w_grant[j]) begin
          // Linear block order: bank is the fast index, address the slow one.
          if (r_cur_bank[j] == LAST_BANK) begin
            r_cur_bank[j] <= '0;
            r_cur_addr[j] <= (r_cur_addr[j] == LAST_ADDR) ? '0 : r_cur_addr[j] + ADDR_W'(1);
          end else begin
            r_cur_bank[j] <= r_cur_bank[j] + BANK_W'(1);
          end
          r_rem[j] <= r_rem[j] - LEN_W'(1);
        end
        r_bank_sel[j*BANK_W +: BANK_W] <= w_grant[j] ? r_cur_bank[j] : '0;
        r_addr_sel[j*ADDR_W +: ADDR_W] <= w_grant[j] ? r_cur_addr[j] : '0;
      end
      r_cmd_err  <= w_accept & w_bad;
      r_en_sel   <= w_grant;
      r_port_sel <= w_port;
      r_last_tag <= w_last;
      r_rd_valid <= r_en_sel;
      r_rd_last  <= r_last_tag;
      if (|w_grant) r_rr_ptr <= r_rr_ptr + PTR_W'(1);
    end
  end

  always_comb begin
    for (int j = 0; j < N_LANE; j++) o_cmd_ready[j] = (r_state[j] == S_IDLE);
  end

  assign o_bank_sel = r_bank_sel;
  assign o_addr_sel = r_addr_sel;
  assign o_en_sel   = r_en_sel;
  assign o_port_sel = r_port_sel;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_last  = r_rd_last;
  assign o_cmd_err  = r_cmd_err;

endmodule
